// File: rtl/cm_pkg.sv
// rtl/cm_pkg.sv - shared widths, latency and tag type for the complex-multiplier scheduler
package cm_pkg;
    localparam int CM_DATA_W   = 12;
    localparam int CM_W_W      = 4;
    localparam int CM_OUT_W    = 17;
    localparam int CM_LAT      = 3;
    localparam int CM_ID_MAX_W = 4;

    // id is sized for the largest supported requester count; users truncate to their ID_W
    typedef struct packed {
        logic                   v;
        logic [CM_ID_MAX_W-1:0] id;
    } cm_tag_t;
endpackage

// File: rtl/cm_rr_scheduler_if.sv
// rtl/cm_rr_scheduler_if.sv - requester request/result bundle for cm_rr_scheduler
interface cm_rr_scheduler_if
    import cm_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ*CM_DATA_W-1:0] req_data_i;
    logic [N_REQ*CM_DATA_W-1:0] req_data_q;
    logic [N_REQ*CM_W_W-1:0]    req_w_i;
    logic [N_REQ*CM_W_W-1:0]    req_w_q;
    logic                       res_valid;
    logic [ID_W-1:0]            res_id;
    logic signed [CM_OUT_W-1:0] res_i;
    logic signed [CM_OUT_W-1:0] res_q;

    modport master (
        output req_valid, req_data_i, req_data_q, req_w_i, req_w_q,
        input  req_ready, res_valid, res_id, res_i, res_q
    );

    modport slave (
        input  req_valid, req_data_i, req_data_q, req_w_i, req_w_q,
        output req_ready, res_valid, res_id, res_i, res_q
    );
endinterface

// File: rtl/cm_rr_pick.sv
// rtl/cm_rr_pick.sv - combinational round-robin pick starting at ptr
module cm_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);
    always_comb begin : pick_search
        int k;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        k       = 0;
        for (int off = 0; off < N_REQ; off++) begin
            k = (int'(ptr_i) + off) % N_REQ;
            if (!any_o && req_valid_i[k]) begin
                any_o      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = ID_W'(k);
            end
        end
    end
endmodule

// File: rtl/complex_mult.sv
// rtl/complex_mult.sv - 3-cycle pipelined complex multiply, signed 12b data by unsigned 4b weight
module complex_mult
    import cm_pkg::*;
(
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        in_en,
    input  logic signed [CM_DATA_W-1:0] in_data_i,
    input  logic signed [CM_DATA_W-1:0] in_data_q,
    input  logic [CM_W_W-1:0]           in_w_i,
    input  logic [CM_W_W-1:0]           in_w_q,
    output logic                        CM_en,
    output logic signed [CM_OUT_W-1:0]  CM_out_i,
    output logic signed [CM_OUT_W-1:0]  CM_out_q
);
    logic                        en1_q, en2_q, en3_q;
    logic signed [CM_OUT_W-1:0]  a_q, b_q, c_q, d_q;
    logic signed [CM_OUT_W-1:0]  ac_q, bd_q, ad_q, bc_q;
    logic signed [CM_OUT_W-1:0]  re_q, im_q;

    // operands widened to the product width so every stage stays in one signed domain
    always_ff @(posedge clk) begin
        if (!rstb) begin
            en1_q <= 1'b0; en2_q <= 1'b0; en3_q <= 1'b0;
            a_q   <= '0;   b_q   <= '0;   c_q   <= '0;   d_q  <= '0;
            ac_q  <= '0;   bd_q  <= '0;   ad_q  <= '0;   bc_q <= '0;
            re_q  <= '0;   im_q  <= '0;
        end else begin
            en1_q <= in_en;
            a_q   <= CM_OUT_W'(in_data_i);
            b_q   <= CM_OUT_W'(in_data_q);
            c_q   <= $signed(CM_OUT_W'(in_w_i));
            d_q   <= $signed(CM_OUT_W'(in_w_q));
            en2_q <= en1_q;
            ac_q  <= a_q * c_q;
            bd_q  <= b_q * d_q;
            ad_q  <= a_q * d_q;
            bc_q  <= b_q * c_q;
            en3_q <= en2_q;
            re_q  <= ac_q - bd_q;
            im_q  <= ad_q + bc_q;
        end
    end

    assign CM_en    = en3_q;
    assign CM_out_i = re_q;
    assign CM_out_q = im_q;
endmodule

// File: rtl/cm_rr_scheduler.sv
// rtl/cm_rr_scheduler.sv - round-robin sharing of one complex_mult; optional CM_SCHED_STATS_EN grant counters
module cm_rr_scheduler
    import cm_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
`ifdef CM_SCHED_STATS_EN
    output logic [N_REQ*CNT_W-1:0]      grant_cnt,
`endif
    input  logic                        clk,
    input  logic                        rstb,
    cm_rr_scheduler_if.slave            req_if,
    output logic                        cm_in_en,
    output logic signed [CM_DATA_W-1:0] cm_data_i,
    output logic signed [CM_DATA_W-1:0] cm_data_q,
    output logic [CM_W_W-1:0]           cm_w_i,
    output logic [CM_W_W-1:0]           cm_w_q,
    input  logic                        cm_en,
    input  logic signed [CM_OUT_W-1:0]  cm_out_i,
    input  logic signed [CM_OUT_W-1:0]  cm_out_q,
    output logic                        err_sync
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_any;
    logic             transfer;
    logic             tag_hit;

    logic [ID_W-1:0]            ptr_q, ptr_d;
    logic                       in_en_q, in_en_d;
    logic signed [CM_DATA_W-1:0] data_i_q, data_i_d, data_q_q, data_q_d;
    logic [CM_W_W-1:0]          w_i_q, w_i_d, w_q_q, w_q_d;
    logic [ID_W-1:0]            id_q, id_d;
    cm_tag_t                    tag_q [CM_LAT];
    logic                       res_valid_q, res_valid_d;
    logic [ID_W-1:0]            res_id_q, res_id_d;
    logic signed [CM_OUT_W-1:0] res_i_q, res_i_d, res_q_q, res_q_d;
    logic                       err_q, err_d;

    cm_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req_valid_i (req_if.req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .idx_o       (grant_idx),
        .any_o       (grant_any)
    );

    assign req_if.req_ready = rstb ? grant : '0;
    assign transfer         = rstb & grant_any;
    assign tag_hit          = cm_en & tag_q[CM_LAT-1].v;

    always_comb begin
        ptr_d    = ptr_q;
        in_en_d  = transfer;
        data_i_d = '0;
        data_q_d = '0;
        w_i_d    = '0;
        w_q_d    = '0;
        id_d     = '0;
        if (transfer) begin
            ptr_d    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            data_i_d = req_if.req_data_i[int'(grant_idx)*CM_DATA_W +: CM_DATA_W];
            data_q_d = req_if.req_data_q[int'(grant_idx)*CM_DATA_W +: CM_DATA_W];
            w_i_d    = req_if.req_w_i[int'(grant_idx)*CM_W_W +: CM_W_W];
            w_q_d    = req_if.req_w_q[int'(grant_idx)*CM_W_W +: CM_W_W];
            id_d     = grant_idx;
        end
        // a multiplier output without a matching tag is dropped, never forwarded
        res_valid_d = tag_hit;
        res_id_d    = tag_hit ? ID_W'(tag_q[CM_LAT-1].id) : '0;
        res_i_d     = tag_hit ? cm_out_i : '0;
        res_q_d     = tag_hit ? cm_out_q : '0;
        err_d       = err_q | (cm_en != tag_q[CM_LAT-1].v);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            ptr_q       <= '0;
            in_en_q     <= 1'b0;
            data_i_q    <= '0;
            data_q_q    <= '0;
            w_i_q       <= '0;
            w_q_q       <= '0;
            id_q        <= '0;
            for (int s = 0; s < CM_LAT; s++) tag_q[s] <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_i_q     <= '0;
            res_q_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            in_en_q     <= in_en_d;
            data_i_q    <= data_i_d;
            data_q_q    <= data_q_d;
            w_i_q       <= w_i_d;
            w_q_q       <= w_q_d;
            id_q        <= id_d;
            // stage0 samples the issued beat as the multiplier does, keeping both paths aligned
            tag_q[0]    <= '{v: in_en_q, id: CM_ID_MAX_W'(id_q)};
            for (int s = 1; s < CM_LAT; s++) tag_q[s] <= tag_q[s-1];
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_i_q     <= res_i_d;
            res_q_q     <= res_q_d;
            err_q       <= err_d;
        end
    end

    assign cm_in_en         = in_en_q;
    assign cm_data_i        = data_i_q;
    assign cm_data_q        = data_q_q;
    assign cm_w_i           = w_i_q;
    assign cm_w_q           = w_q_q;
    assign req_if.res_valid = res_valid_q;
    assign req_if.res_id    = res_id_q;
    assign req_if.res_i     = res_i_q;
    assign req_if.res_q     = res_q_q;
    assign err_sync         = err_q;

`ifdef CM_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_REQ; k++) begin
            if (!rstb) begin
                cnt_q[k] <= '0;
            end else if (transfer && grant[k] && (cnt_q[k] != '1)) begin
                cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif
endmodule

// File: tb/tb_cm_rr_scheduler.sv
// tb/tb_cm_rr_scheduler.sv - randomized self-checking bench for cm_rr_scheduler with complex_mult
module tb_cm_rr_scheduler;
    import cm_pkg::*;

    localparam int N = 4;

    typedef struct {
        int due;
        int id;
        int ri;
        int rq;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb;
    logic force_en;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cm_rr_scheduler_if #(.N_REQ(N)) bus ();

    logic                cm_in_en, mult_en, cm_en, err_sync;
    logic signed [11:0]  cm_data_i, cm_data_q;
    logic [3:0]          cm_w_i, cm_w_q;
    logic signed [16:0]  cm_out_i, cm_out_q;
`ifdef CM_SCHED_STATS_EN
    logic [N*16-1:0]     grant_cnt;
`endif

    assign cm_en = mult_en | force_en;

    cm_rr_scheduler #(.N_REQ(N), .CNT_W(16)) dut (
`ifdef CM_SCHED_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .clk       (clk),
        .rstb      (rstb),
        .req_if    (bus),
        .cm_in_en  (cm_in_en),
        .cm_data_i (cm_data_i),
        .cm_data_q (cm_data_q),
        .cm_w_i    (cm_w_i),
        .cm_w_q    (cm_w_q),
        .cm_en     (cm_en),
        .cm_out_i  (cm_out_i),
        .cm_out_q  (cm_out_q),
        .err_sync  (err_sync)
    );

    complex_mult u_mult (
        .clk       (clk),
        .rstb      (rstb),
        .in_en     (cm_in_en),
        .in_data_i (cm_data_i),
        .in_data_q (cm_data_q),
        .in_w_i    (cm_w_i),
        .in_w_q    (cm_w_q),
        .CM_en     (mult_en),
        .CM_out_i  (cm_out_i),
        .CM_out_q  (cm_out_q)
    );

    int   da [N];
    int   dq [N];
    int   wi [N];
    int   wq [N];
    exp_t sb [$];

    task automatic load_bus();
        for (int k = 0; k < N; k++) begin
            bus.req_data_i[k*12 +: 12] = 12'(da[k]);
            bus.req_data_q[k*12 +: 12] = 12'(dq[k]);
            bus.req_w_i[k*4 +: 4]      = 4'(wi[k]);
            bus.req_w_q[k*4 +: 4]      = 4'(wq[k]);
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) begin
            da[k] = int'($urandom_range(4095)) - 2048;
            dq[k] = int'($urandom_range(4095)) - 2048;
            wi[k] = int'($urandom_range(15));
            wq[k] = int'($urandom_range(15));
        end
        load_bus();
    endtask

    function automatic int model_pick(logic [N-1:0] v, int p);
        for (int off = 0; off < N; off++) begin
            if (v[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    function automatic int prod_i(int k);
        return da[k] * wi[k] - dq[k] * wq[k];
    endfunction

    function automatic int prod_q(int k);
        return da[k] * wq[k] + dq[k] * wi[k];
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1 rstb = 1'b0;
        bus.req_valid = '0;
        force_en      = 1'b0;
        @(posedge clk);
        #1 rstb = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1 bus.req_valid = '1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready); end
        checks++; if (cm_in_en !== 1'b0) begin errors++; $display("FAIL reset_cm_in_en got %b exp 0", cm_in_en); end
        checks++; if (cm_data_i !== 12'sd0) begin errors++; $display("FAIL reset_cm_data got %0d exp 0", cm_data_i); end
        checks++; if (bus.res_valid !== 1'b0 || bus.res_i !== 17'sd0 || bus.res_id !== 2'd0) begin
            errors++; $display("FAIL reset_res got v=%b id=%0d i=%0d exp 0", bus.res_valid, bus.res_id, bus.res_i); end
        checks++; if (err_sync !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_sync); end
        @(posedge clk);
        #1 rstb = 1'b1;
        bus.req_valid = '0;
    endtask

    task automatic test_single();
        int  t0;
        int  lat;
        logic got;
        do_reset();
        da[0] = 100; dq[0] = -50; wi[0] = 3; wq[0] = 2;
        load_bus();
        bus.req_valid = 4'b0001;
        @(negedge clk);
        t0 = cyc;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        @(negedge clk);
        checks++; if (cm_in_en !== 1'b1 || cm_data_i !== 12'sd100 || cm_data_q !== -12'sd50 || cm_w_i !== 4'd3 || cm_w_q !== 4'd2) begin
            errors++; $display("FAIL single_cm_regs got en=%b %0d %0d %0d %0d exp 1 100 -50 3 2", cm_in_en, cm_data_i, cm_data_q, cm_w_i, cm_w_q); end
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin got = 1'b1; lat = cyc - t0; end
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL single_latency got %0d exp 5", lat); end
        checks++; if (bus.res_id !== 2'd0 || bus.res_i !== 17'sd400 || bus.res_q !== 17'sd50) begin
            errors++; $display("FAIL single_result got id=%0d i=%0d q=%0d exp 0 400 50", bus.res_id, bus.res_i, bus.res_q); end
        @(negedge clk);
        checks++; if (bus.res_valid !== 1'b0 || bus.res_i !== 17'sd0 || bus.res_q !== 17'sd0) begin
            errors++; $display("FAIL single_idle got v=%b i=%0d q=%0d exp 0", bus.res_valid, bus.res_i, bus.res_q); end
    endtask

    task automatic test_back_to_back();
        int bi [12];
        int bq [12];
        logic [N-1:0] er;
        do_reset();
        bus.req_valid = '1;
        for (int i = 0; i < 18; i++) begin
            if (i < 12) rand_data();
            else bus.req_valid = '0;
            @(negedge clk);
            if (i < 12) begin
                er = '0;
                er[i % N] = 1'b1;
                bi[i] = prod_i(i % N);
                bq[i] = prod_q(i % N);
                checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL b2b_grant%0d got %b exp %b", i, bus.req_ready, er); end
            end
            if (i >= 5 && i < 17) begin
                checks++;
                if (bus.res_valid !== 1'b1 || bus.res_id !== 2'((i - 5) % N) || bus.res_i !== 17'(bi[i-5]) || bus.res_q !== 17'(bq[i-5])) begin
                    errors++; $display("FAIL b2b_res%0d got v=%b id=%0d i=%0d q=%0d exp 1 %0d %0d %0d",
                        i - 5, bus.res_valid, bus.res_id, bus.res_i, bus.res_q, (i - 5) % N, bi[i-5], bq[i-5]); end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] exp_seq [3];
        exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b1000;
        do_reset();
        bus.req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_first got %b exp 0100", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== exp_seq[i]) begin errors++; $display("FAIL wrap_step%0d got %b exp %b", i, bus.req_ready, exp_seq[i]); end
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_reset_flight();
        int   seen;
        int   t0;
        int   lat;
        int   ei;
        logic got;
        do_reset();
        rand_data();
        bus.req_valid = '1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rstb = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL flight_ready_in_reset got %b exp 0000", bus.req_ready); end
        @(posedge clk);
        #1 rstb = 1'b1;
        bus.req_valid = '0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flight_stale_results got %0d exp 0", seen); end
        checks++; if (err_sync !== 1'b0) begin errors++; $display("FAIL flight_err got %b exp 0", err_sync); end
        @(posedge clk);
        #1 rand_data();
        bus.req_valid = 4'b0001;
        ei = prod_i(0);
        @(negedge clk);
        t0 = cyc;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL flight_next_ready got %b exp 0001", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin got = 1'b1; lat = cyc - t0; end
        end
        checks++; if (lat !== 5 || bus.res_i !== 17'(ei)) begin
            errors++; $display("FAIL flight_next_result got lat=%0d i=%0d exp 5 %0d", lat, bus.res_i, ei); end
    endtask

    task automatic test_traffic(int n, int pct);
        int   mptr;
        int   k;
        exp_t e;
        logic [N-1:0] v;
        logic [N-1:0] er;
        do_reset();
        sb.delete();
        mptr = 0;
        for (int i = 0; i < n + 6; i++) begin
            v = '0;
            if (i < n) for (int j = 0; j < N; j++) v[j] = ($urandom_range(99) < pct);
            rand_data();
            bus.req_valid = v;
            @(negedge clk);
            k  = model_pick(v, mptr);
            er = '0;
            if (k >= 0) er[k] = 1'b1;
            checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL traffic_grant cyc %0d got %b exp %b", cyc, bus.req_ready, er); end
            if (k >= 0) begin
                sb.push_back('{cyc + 5, k, prod_i(k), prod_q(k)});
                mptr = (k + 1) % N;
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(e.id) || bus.res_i !== 17'(e.ri) || bus.res_q !== 17'(e.rq)) begin
                    errors++; $display("FAIL traffic_result cyc %0d got v=%b id=%0d i=%0d q=%0d exp 1 %0d %0d %0d",
                        cyc, bus.res_valid, bus.res_id, bus.res_i, bus.res_q, e.id, e.ri, e.rq); end
            end else begin
                checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL traffic_spurious cyc %0d got %b exp 0", cyc, bus.res_valid); end
            end
            @(posedge clk);
            #1;
        end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL traffic_missing got %0d pending exp 0", sb.size()); end
    endtask

    task automatic test_sync_err();
        do_reset();
        @(negedge clk);
        checks++; if (err_sync !== 1'b0) begin errors++; $display("FAIL syncerr_before got %b exp 0", err_sync); end
        @(posedge clk);
        #1 force_en = 1'b1;
        @(posedge clk);
        #1 force_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (err_sync !== 1'b1 || bus.res_valid !== 1'b0) begin
                errors++; $display("FAIL syncerr_hold%0d got err=%b v=%b exp 1 0", i, err_sync, bus.res_valid); end
        end
    endtask

`ifdef CM_SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++; if (err_sync !== 1'b0) begin errors++; $display("FAIL stats_err_cleared got %b exp 0", err_sync); end
        checks++; if (grant_cnt !== '0) begin errors++; $display("FAIL stats_reset got %h exp 0", grant_cnt); end
        bus.req_valid = 4'b0001;
        repeat (1000) @(posedge clk);
        #1;
        checks++; if (grant_cnt[15:0] !== 16'd1000) begin errors++; $display("FAIL stats_1000 got %0d exp 1000", grant_cnt[15:0]); end
        repeat (69000) @(posedge clk);
        #1 bus.req_valid = '0;
        checks++; if (grant_cnt[15:0] !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got %0d exp 65535", grant_cnt[15:0]); end
        checks++; if (grant_cnt[63:16] !== 48'd0) begin errors++; $display("FAIL stats_others got %h exp 0", grant_cnt[63:16]); end
    endtask
`endif

    initial begin
        rstb          = 1'b0;
        force_en      = 1'b0;
        bus.req_valid = '0;
        rand_data();
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_reset_flight();
        test_traffic(300, 60);
        test_traffic(300, 20);
        test_sync_err();
`ifdef CM_SCHED_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
